// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing control.
// Latency: n/a (package).
// Backpressure: n/a (package).
package pipe_ctrl_pkg;

  // RUN: normal flow. WAIT: data memory busy, whole pipe frozen.
  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } ctrl_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int CNT_W_DEF    = 16;
  localparam int WAIT_MAX_DEF = 255;

  // The wait timer is at least 8 bits and always wide enough to hold WAIT_MAX.
  function automatic int timer_width(input int wait_max);
    int w;
    w = $clog2(wait_max + 1);
    return (w < 8) ? 8 : w;
  endfunction

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// Load-use hazard compare between the load in EX and the source regs in ID.
// Latency: purely combinational, zero cycles.
// Backpressure: none; caller decides what a hit means for its enables.
// Ports:
//   ex_mem_read_i  MemRead of the instruction in EX
//   ex_rt_i        destination register of the load in EX
//   id_rs_i/rt_i   source register fields of the instruction in ID
//   lu_o           1 when ID needs a value the load has not produced yet
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rt_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  output logic       lu_o
);

  // r0 is hardwired, so a load targeting it can never create a dependency.
  assign lu_o = ex_mem_read_i && (ex_rt_i != REG_ZERO) &&
                ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));

endmodule

// File: rtl/hazard_ctrl.sv
// Sequences PC, IF/ID and ID/EX: load-use bubbles, branch flushes, memory freeze.
// Latency: all enables combinational from inputs (zero cycles); counters/timeout one cycle.
// Backpressure: mem_busy_i freezes every stage; a load-use stalls PC and IF/ID for one cycle.
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   IFID_RSaddr_i/IFID_RTaddr_i       source regs of the instruction in ID
//   IDEX_MemRead_i/IDEX_RTaddr_i      load in EX and its destination
//   Branch_taken_i                    branch in ID resolved taken
//   mem_busy_i                        data memory not ready
//   PC_we_o, IFID_we_o, IFID_flush_o, IDEX_we_o, IDEX_flush_o, pipe_hold_o  stage controls
//   timeout_o                         sticky memory-wait timeout
//   lu_cnt_o, flush_cnt_o, wait_cnt_o saturating event counters
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       IFID_RSaddr_i,
  input  logic [4:0]       IFID_RTaddr_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_RTaddr_i,
  input  logic             Branch_taken_i,
  input  logic             mem_busy_i,
  output logic             PC_we_o,
  output logic             IFID_we_o,
  output logic             IFID_flush_o,
  output logic             IDEX_we_o,
  output logic             IDEX_flush_o,
  output logic             pipe_hold_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] lu_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] wait_cnt_o
);

  localparam int               TMR_W      = timer_width(WAIT_MAX);
  localparam logic [TMR_W-1:0] WAIT_MAX_T = TMR_W'(WAIT_MAX);

  ctrl_state_t      state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             timeout_q, timeout_d;
  logic             post_rst_q, post_rst_d;
  logic             lu;
  logic             busy_eff;
  logic [2:0]       cnt_ev;

  load_use_detect u_lu (
    .ex_mem_read_i (IDEX_MemRead_i),
    .ex_rt_i       (IDEX_RTaddr_i),
    .id_rs_i       (IFID_RSaddr_i),
    .id_rt_i       (IFID_RTaddr_i),
    .lu_o          (lu)
  );

  // The first cycle after reset runs normally even if memory still reports
  // busy; a lingering busy takes effect (and enters WAIT) one cycle later.
  assign busy_eff = mem_busy_i && !post_rst_q;

  // Stage enables. Priority: reset > busy > load-use > branch.
  // A load-use that coincides with a taken branch stalls only; the branch
  // stays in ID and flushes once the bubble has cleared the hazard.
  always_comb begin
    PC_we_o      = 1'b1;
    IFID_we_o    = 1'b1;
    IFID_flush_o = 1'b0;
    IDEX_we_o    = 1'b1;
    IDEX_flush_o = 1'b0;
    pipe_hold_o  = 1'b0;
    if (rst_i) begin
      PC_we_o      = 1'b0;
      IFID_we_o    = 1'b0;
      IFID_flush_o = 1'b1;
      IDEX_flush_o = 1'b1;
    end else if (busy_eff) begin
      PC_we_o     = 1'b0;
      IFID_we_o   = 1'b0;
      IDEX_we_o   = 1'b0;
      pipe_hold_o = 1'b1;
    end else if (lu) begin
      PC_we_o      = 1'b0;
      IFID_we_o    = 1'b0;
      IDEX_flush_o = 1'b1;
    end else if (Branch_taken_i) begin
      IFID_flush_o = 1'b1;
    end
  end

  // Next state and wait timer. The timer counts frozen cycles of the current
  // busy episode: entering WAIT loads 1 for the cycle that caused the entry,
  // and it stops at WAIT_MAX so it never wraps during a long freeze.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    timeout_d  = timeout_q;
    post_rst_d = 1'b0;
    case (state_q)
      RUN: begin
        if (busy_eff) begin
          state_d = WAIT;
          timer_d = TMR_W'(1);
        end
      end
      WAIT: begin
        if (!busy_eff) begin
          state_d = RUN;
        end else if (timer_q < WAIT_MAX_T) begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = RUN;
    endcase
    if (busy_eff && (timer_d >= WAIT_MAX_T)) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= RUN;
      timer_q    <= '0;
      timeout_q  <= 1'b0;
      post_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      timeout_q  <= timeout_d;
      post_rst_q <= post_rst_d;
    end
  end

  assign timeout_o = timeout_q;

  // Counter events mirror what the enables are doing this cycle.
  assign cnt_ev[0] = !rst_i && !busy_eff && lu;
  assign cnt_ev[1] = !rst_i && !busy_eff && !lu && Branch_taken_i;
  assign cnt_ev[2] = !rst_i && busy_eff;

  for (genvar g = 0; g < 3; g++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (cnt_ev[g] && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  assign lu_cnt_o    = g_cnt[0].cnt_q;
  assign flush_cnt_o = g_cnt[1].cnt_q;
  assign wait_cnt_o  = g_cnt[2].cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: default instance plus a small one
// (3-bit counters, WAIT_MAX=3) sharing the same stimulus.
module tb_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int S_CNT_W = 3;
  localparam int S_WMAX  = 3;

  localparam logic [5:0] EN_NORM  = 6'b110100;
  localparam logic [5:0] EN_STALL = 6'b000110;
  localparam logic [5:0] EN_BR    = 6'b111100;
  localparam logic [5:0] EN_FRZ   = 6'b000001;
  localparam logic [5:0] EN_RST   = 6'b001110;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] rs, rt, exrt;
  logic       mr, br, busy;

  logic        a_pc, a_ifwe, a_iffl, a_idwe, a_idfl, a_hold, a_to;
  logic [15:0] a_lu, a_fl, a_wt;
  logic        b_pc, b_ifwe, b_iffl, b_idwe, b_idfl, b_hold, b_to;
  logic [S_CNT_W-1:0] b_lu, b_fl, b_wt;

  hazard_ctrl dut_a (
    .clk_i(clk), .rst_i(rst), .IFID_RSaddr_i(rs), .IFID_RTaddr_i(rt),
    .IDEX_MemRead_i(mr), .IDEX_RTaddr_i(exrt), .Branch_taken_i(br), .mem_busy_i(busy),
    .PC_we_o(a_pc), .IFID_we_o(a_ifwe), .IFID_flush_o(a_iffl), .IDEX_we_o(a_idwe),
    .IDEX_flush_o(a_idfl), .pipe_hold_o(a_hold), .timeout_o(a_to),
    .lu_cnt_o(a_lu), .flush_cnt_o(a_fl), .wait_cnt_o(a_wt)
  );

  hazard_ctrl #(.CNT_W(S_CNT_W), .WAIT_MAX(S_WMAX)) dut_b (
    .clk_i(clk), .rst_i(rst), .IFID_RSaddr_i(rs), .IFID_RTaddr_i(rt),
    .IDEX_MemRead_i(mr), .IDEX_RTaddr_i(exrt), .Branch_taken_i(br), .mem_busy_i(busy),
    .PC_we_o(b_pc), .IFID_we_o(b_ifwe), .IFID_flush_o(b_iffl), .IDEX_we_o(b_idwe),
    .IDEX_flush_o(b_idfl), .pipe_hold_o(b_hold), .timeout_o(b_to),
    .lu_cnt_o(b_lu), .flush_cnt_o(b_fl), .wait_cnt_o(b_wt)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Tracks: whether we are in the first cycle after reset, the length of
  // the current freeze run, and per-instance event totals clipped at max.
  bit m_first = 1'b1;
  int m_run   = 0;
  bit m_to[2];
  int m_lu[2], m_fl[2], m_wt[2];
  int cmax[2] = '{65535, 7};
  int wmax[2] = '{255, S_WMAX};

  function automatic bit m_hazard();
    return mr && (exrt != 5'd0) && ((exrt == rs) || (exrt == rt));
  endfunction

  function automatic logic [5:0] m_en();
    if (rst) return EN_RST;
    if (busy && !m_first) return EN_FRZ;
    if (m_hazard()) return EN_STALL;
    if (br) return EN_BR;
    return EN_NORM;
  endfunction

  task automatic m_clock();
    bit fr, hz;
    if (rst) begin
      m_first = 1'b1;
      m_run   = 0;
      for (int i = 0; i < 2; i++) begin
        m_to[i] = 1'b0; m_lu[i] = 0; m_fl[i] = 0; m_wt[i] = 0;
      end
    end else begin
      fr = busy && !m_first;
      hz = m_hazard();
      if (fr) m_run++;
      else m_run = 0;
      for (int i = 0; i < 2; i++) begin
        if (fr) begin
          if (m_wt[i] < cmax[i]) m_wt[i]++;
          if (m_run >= wmax[i]) m_to[i] = 1'b1;
        end else if (hz) begin
          if (m_lu[i] < cmax[i]) m_lu[i]++;
        end else if (br) begin
          if (m_fl[i] < cmax[i]) m_fl[i]++;
        end
      end
      m_first = 1'b0;
    end
  endtask

  // Sample at negedge and compare every output against the model.
  task automatic at_neg();
    @(negedge clk);
    chk("en_a", {a_pc, a_ifwe, a_iffl, a_idwe, a_idfl, a_hold}, m_en());
    chk("en_b", {b_pc, b_ifwe, b_iffl, b_idwe, b_idfl, b_hold}, m_en());
    chk("stat_a", {a_to, a_lu, a_fl, a_wt},
        {m_to[0], 16'(m_lu[0]), 16'(m_fl[0]), 16'(m_wt[0])});
    chk("stat_b", {b_to, b_lu, b_fl, b_wt},
        {m_to[1], 3'(m_lu[1]), 3'(m_fl[1]), 3'(m_wt[1])});
  endtask

  task automatic to_pos();
    @(posedge clk);
    m_clock();
    #1;
  endtask

  task automatic idle();
    rs = 5'd1; rt = 5'd2; exrt = 5'd3; mr = 1'b0; br = 1'b0; busy = 1'b0;
  endtask

  task automatic do_reset(input int n);
    idle();
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      at_neg();
      chk("rst_en", {a_pc, a_ifwe, a_iffl, a_idwe, a_idfl, a_hold}, EN_RST);
      to_pos();
    end
    rst = 1'b0;
  endtask

  typedef struct {
    logic       rst;
    logic [4:0] rs, rt;
    logic       mr;
    logic [4:0] exrt;
    logic       br, busy;
    logic [5:0] en;
  } vec_t;

  vec_t vecs[12];

  initial begin
    // rst rs rt mr exrt br busy expected
    vecs[0]  = '{1'b0, 5'd1, 5'd2, 1'b0, 5'd1, 1'b0, 1'b0, EN_NORM};
    vecs[1]  = '{1'b0, 5'd5, 5'd2, 1'b1, 5'd5, 1'b0, 1'b0, EN_STALL};
    vecs[2]  = '{1'b0, 5'd3, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, EN_STALL};
    vecs[3]  = '{1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, EN_NORM};
    vecs[4]  = '{1'b0, 5'd1, 5'd2, 1'b1, 5'd9, 1'b0, 1'b0, EN_NORM};
    vecs[5]  = '{1'b0, 5'd1, 5'd2, 1'b0, 5'd1, 1'b1, 1'b0, EN_BR};
    vecs[6]  = '{1'b0, 5'd4, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0, EN_STALL};
    vecs[7]  = '{1'b0, 5'd4, 5'd2, 1'b1, 5'd4, 1'b1, 1'b1, EN_FRZ};
    vecs[8]  = '{1'b0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, EN_FRZ};
    vecs[9]  = '{1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, EN_RST};
    vecs[10] = '{1'b0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, EN_NORM};
    vecs[11] = '{1'b0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, EN_FRZ};

    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset held two cycles, then release.
    do_reset(2);
    at_neg();
    chk("rel_pc_we", a_pc, 1'b1);
    chk("rel_counters", {a_lu, a_fl, a_wt, a_to}, 49'd0);
    to_pos();

    // Table-driven vectors.
    for (int i = 0; i < 12; i++) begin
      rst = vecs[i].rst; rs = vecs[i].rs; rt = vecs[i].rt; mr = vecs[i].mr;
      exrt = vecs[i].exrt; br = vecs[i].br; busy = vecs[i].busy;
      at_neg();
      chk($sformatf("vec%0d", i), {a_pc, a_ifwe, a_iffl, a_idwe, a_idfl, a_hold}, vecs[i].en);
      to_pos();
    end

    // Load-use: single bubble, then the bubble clears MemRead in EX.
    do_reset(1);
    to_pos();
    mr = 1'b1; exrt = 5'd5; rs = 5'd5;
    at_neg();
    chk("lu_stall", {a_pc, a_ifwe, a_idfl}, 3'b001);
    to_pos();
    mr = 1'b0;
    at_neg();
    chk("lu_after", {a_pc, a_ifwe, a_idfl}, 3'b110);
    chk("lu_cnt1", a_lu, 16'd1);
    to_pos();

    // Branch alone, then branch with load-use: stall first, flush next.
    idle(); br = 1'b1;
    at_neg();
    chk("br_alone", {a_pc, a_iffl}, 2'b11);
    to_pos();
    mr = 1'b1; exrt = 5'd6; rs = 5'd6;
    at_neg();
    chk("br_lu_fl", a_fl, 16'd1);
    chk("br_lu_stall", {a_iffl, a_idfl, a_pc}, 3'b010);
    to_pos();
    mr = 1'b0;
    at_neg();
    chk("br_follow", {a_iffl, a_pc}, 2'b11);
    to_pos();
    at_neg();
    chk("br_fl2", a_fl, 16'd2);
    to_pos();

    // Busy 4 cycles on default instance; 6 cycles total for timeout on small one.
    do_reset(1);
    to_pos();
    busy = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      at_neg();
      chk("busy_frz", {a_pc, a_ifwe, a_idwe, a_hold}, 4'b0001);
      chk("b_timeout_rise", b_to, (k >= 4) ? 1'b1 : 1'b0);
      if (k == 4) busy = 1'b1;
      to_pos();
      if (k == 4) begin
        busy = 1'b0;
        at_neg();
        chk("busy_run5", {a_pc, a_ifwe, a_idwe, a_hold}, 4'b1110);
        chk("wait_cnt4", a_wt, 16'd4);
        chk("a_no_timeout", a_to, 1'b0);
        to_pos();
        busy = 1'b1;
      end
    end
    busy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      at_neg();
      chk("b_timeout_sticky", b_to, 1'b1);
      to_pos();
    end
    do_reset(1);
    at_neg();
    chk("b_timeout_clr", b_to, 1'b0);
    to_pos();

    // Saturation on 3-bit counters.
    mr = 1'b1; exrt = 5'd8; rt = 5'd8;
    for (int k = 0; k < 9; k++) begin
      at_neg();
      to_pos();
    end
    at_neg();
    chk("lu_sat_b", b_lu, 3'b111);
    chk("lu_nosat_a", a_lu, 16'd9);
    to_pos();

    // Randomized run checked against the model every cycle.
    do_reset(1);
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 99) == 0);
      rs   = 5'($urandom_range(0, 3));
      rt   = 5'($urandom_range(0, 3));
      exrt = 5'($urandom_range(0, 3));
      mr   = ($urandom_range(0, 1) == 1);
      br   = ($urandom_range(0, 2) == 0);
      busy = ($urandom_range(0, 3) == 0);
      at_neg();
      to_pos();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
